// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a little-endian byte stream into 32-bit words and programs instruction memory
// Core is held in reset until a range-checked image has been completely written.
module imem_loader #(
  parameter int IMEM_DEPTH      = 2048,
  parameter int IMEM_ADDR_WIDTH = $clog2(IMEM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       i_start,
  input  logic [IMEM_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [IMEM_ADDR_WIDTH:0]   i_len_words,
  input  logic                       i_valid,
  input  logic [7:0]                 i_data,
  output logic                       o_ready,
  output logic                       o_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_addr,
  output logic [31:0]                o_wdata,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic                       o_core_rst_,
  output logic [15:0]                o_csum
);

  localparam int AW = IMEM_ADDR_WIDTH;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(IMEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [AW:0]   word_cnt_q;
  logic [1:0]    byte_cnt_q;
  logic [23:0]   lanes_q;
  logic [15:0]   csum_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [AW+1:0] end_addr_d;
  logic [AW:0]   word_cnt_d;

  // Widened so base + len can exceed the depth without wrapping.
  assign end_addr_d = {2'b00, i_base_addr} + {1'b0, i_len_words};
  assign word_cnt_d = word_cnt_q + (AW+1)'(1);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      lanes_q    <= '0;
      csum_q     <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            base_q     <= i_base_addr;
            len_q      <= i_len_words;
            csum_q     <= '0;
            err_q      <= 1'b0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            if (end_addr_d > DEPTH_W) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (i_len_words == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (i_valid) begin
            csum_q     <= csum_q + {8'h00, i_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0: lanes_q[7:0]   <= i_data;
              2'd1: lanes_q[15:8]  <= i_data;
              2'd2: lanes_q[23:16] <= i_data;
              default: begin
                addr_q  <= base_q + word_cnt_q[AW-1:0];
                wdata_q <= {i_data, lanes_q};
                state_q <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          word_cnt_q <= word_cnt_d;
          byte_cnt_q <= '0;
          state_q    <= (word_cnt_d == len_q) ? S_DONE : S_LOAD;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ready     = (state_q == S_LOAD);
  assign o_we        = (state_q == S_WRITE);
  assign o_busy      = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = err_q;
  assign o_core_rst_ = (state_q == S_DONE) && !err_q;
  assign o_addr      = addr_q;
  assign o_wdata     = wdata_q;
  assign o_csum      = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed and randomized checks of imem_loader against a memory/image model
module tb_imem_loader;

  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          rst_;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [AW:0]   i_len_words;
  logic          i_valid;
  logic [7:0]    i_data;
  logic          o_ready, o_we, o_busy, o_done, o_err, o_core_rst_;
  logic [AW-1:0] o_addr;
  logic [31:0]   o_wdata;
  logic [15:0]   o_csum;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:DEPTH-1];
  int          we_cnt = 0;
  logic [7:0]  bq [$];
  int          bi;

  imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_(rst_), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_len_words(i_len_words), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_core_rst_(o_core_rst_),
    .o_csum(o_csum)
  );

  always #5 clk = ~clk;

  // Memory model: captures whatever the loader writes.
  always @(posedge clk) begin
    if (rst_ === 1'b1 && o_we === 1'b1) begin
      mem[o_addr] <= o_wdata;
      we_cnt      <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input int base, input int len);
    @(negedge clk);
    i_start     = 1'b1;
    i_base_addr = AW'(base);
    i_len_words = (AW+1)'(len);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // mode 0: valid held, 1: valid toggles, 2: random valid
  task automatic feed(input string tag, input int n, input int mode);
    int   got = 0;
    int   cyc = 0;
    logic v, rdy;
    while (got < n && cyc < 1000) begin
      @(negedge clk);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      i_valid = v;
      i_data  = (bi < bq.size()) ? bq[bi] : 8'h00;
      rdy     = o_ready;
      @(posedge clk);
      if (v && rdy) begin
        bi++;
        got++;
      end
      cyc++;
    end
    #1 i_valid = 1'b0;
    chk({tag, "_feed_count"}, got, n);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (o_done !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done_in_time"}, 32'(c < 200), 1);
  endtask

  task automatic rand_bytes(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
    bi = 0;
  endtask

  // Expected image: word i is bytes 4i..4i+3, little-endian; csum is the byte sum mod 2^16.
  task automatic check_load(input string tag, input int base, input int len, input int we0);
    logic [15:0] s = 16'h0;
    logic [31:0] w;
    for (int i = 0; i < 4 * len; i++) s = s + 16'(bq[i]);
    @(negedge clk);
    chk({tag, "_we_count"}, we_cnt - we0, len);
    for (int i = 0; i < len; i++) begin
      w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
      chk($sformatf("%s_word%0d", tag, i), mem[base+i], w);
    end
    chk({tag, "_csum"}, o_csum, s);
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_core_rst"}, o_core_rst_, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, o_ready, 0);
    chk({tag, "_we"}, o_we, 0);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_wdata"}, o_wdata, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_core_rst"}, o_core_rst_, 0);
    chk({tag, "_csum"}, o_csum, 0);
  endtask

  initial begin
    int w0, base, len;
    rst_ = 1'b0; i_start = 1'b0; i_base_addr = '0; i_len_words = '0;
    i_valid = 1'b0; i_data = 8'h00; bi = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_ = 1'b1;

    // Directed image, valid held high
    bq = '{8'h13, 8'h03, 8'h10, 8'h00, 8'h93, 8'h03, 8'h20, 8'h00};
    bi = 0; w0 = we_cnt;
    start(0, 2);
    chk("held_ready_after_start", o_ready, 1);
    chk("held_busy_after_start", o_busy, 1);
    feed("held", 8, 0);
    wait_done("held");
    @(negedge clk);
    chk("held_addr0", mem[0], 32'h00100313);
    chk("held_addr1", mem[1], 32'h00200393);
    chk("held_we_count", we_cnt - w0, 2);
    chk("held_csum", o_csum, 32'h00DC);
    chk("held_core_rst", o_core_rst_, 1);

    // Same image with toggled valid
    bi = 0; w0 = we_cnt;
    start(10, 2);
    feed("toggle", 8, 1);
    wait_done("toggle");
    check_load("toggle", 10, 2, w0);

    // Range error
    w0 = we_cnt;
    start(2046, 3);
    chk("range_done", o_done, 1);
    chk("range_err", o_err, 1);
    chk("range_core_rst", o_core_rst_, 0);
    chk("range_busy", o_busy, 0);
    repeat (4) @(negedge clk);
    chk("range_no_we", we_cnt - w0, 0);
    chk("range_core_rst_held", o_core_rst_, 0);

    // Last two words of memory
    rand_bytes(8); w0 = we_cnt;
    start(2046, 2);
    feed("top", 8, 2);
    wait_done("top");
    check_load("top", 2046, 2, w0);

    // Zero length
    w0 = we_cnt;
    start(5, 0);
    chk("zero_done", o_done, 1);
    chk("zero_core_rst", o_core_rst_, 1);
    chk("zero_csum", o_csum, 0);
    chk("zero_err", o_err, 0);
    repeat (3) @(negedge clk);
    chk("zero_no_we", we_cnt - w0, 0);

    // Reset mid-load after 6 bytes, then restart
    rand_bytes(8); w0 = we_cnt;
    start(0, 2);
    feed("abort", 6, 0);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    check_reset_vals("abort_async");
    chk("abort_we_count", we_cnt - w0, 1);
    chk("abort_word0", mem[0], {bq[3], bq[2], bq[1], bq[0]});
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    bi = 0; w0 = we_cnt;
    start(0, 2);
    feed("restart", 8, 0);
    wait_done("restart");
    check_load("restart", 0, 2, w0);

    // i_start during LOAD is ignored
    rand_bytes(8); w0 = we_cnt;
    start(20, 2);
    feed("ign_a", 2, 0);
    start(100, 1);
    chk("ign_still_busy", o_busy, 1);
    chk("ign_still_ready", o_ready, 1);
    feed("ign_b", 6, 0);
    wait_done("ign");
    check_load("ign", 20, 2, w0);

    // i_start in DONE drops core reset and reloads
    rand_bytes(4); w0 = we_cnt;
    start(30, 1);
    chk("redo_core_rst_low", o_core_rst_, 0);
    chk("redo_done_low", o_done, 0);
    chk("redo_ready", o_ready, 1);
    feed("redo", 4, 2);
    wait_done("redo");
    check_load("redo", 30, 1, w0);

    // Randomized loads
    for (int it = 0; it < 6; it++) begin
      len  = $urandom_range(1, 6);
      base = $urandom_range(0, DEPTH - len);
      rand_bytes(4 * len); w0 = we_cnt;
      start(base, len);
      feed($sformatf("rnd%0d", it), 4 * len, $urandom_range(0, 2));
      wait_done($sformatf("rnd%0d", it));
      check_load($sformatf("rnd%0d", it), base, len, w0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
